lanes_deserializer: RTL and testbench
=====================================

// Module: lanes_deserializer
// PURPOSE
//  Receive-side counterpart of the two-lane transmit serializer. Samples one bit per clk
//  from each of lane 0 and lane 1 and reassembles parallel words: 8b (gen4), 132b (gen3)
//  or 66b (gen2), with the bit ordering and word size the transmitter uses. Drives the
//  assembled words to the descrambler stage with a one-cycle valid strobe. Also drives a
//  descrambler seed-reset pulse aligned to the first word of each enabled session.
// PARAMETERS
//  ALIGN_DELAY  2    serial cycles discarded after enable rises, before bit 0 of word 0.
//                    Matches the transmitter's load-plus-register pipeline.
//  MAX_W        132  width of the parallel word ports
// PORTS
//  clk            in   1      clock; one serial bit per lane per rising edge
//  rst            in   1      asynchronous, active-low reset
//  enable         in   1      high = deserialize; low = idle and flush
//  gen_speed      in   2      00 gen4 (8b, MSB first); 01 gen3 (132b, LSB first);
//                             10 gen2 (66b, LSB first); 11 treated as 00
//  lane_0_rx_in   in   1      lane 0 serial data
//  lane_1_rx_in   in   1      lane 1 serial data
//  lane_0_rx_out  out  MAX_W  lane 0 assembled word; bits above word size are 0
//  lane_1_rx_out  out  MAX_W  lane 1 assembled word; bits above word size are 0
//  rx_valid       out  1      one-cycle strobe: both rx_out words are new this cycle
//  descr_rst      out  1      one-cycle pulse with the first rx_valid of a session
// BEHAVIOUR
//  Reset (rst=0, async):
//   - All outputs 0, shift registers 0, counters 0, state IDLE.
//  Word size N:
//   - N = 8 / 132 / 66 per gen_speed.
//   - gen_speed is latched on the enable 0->1 edge. Later changes are ignored until
//     enable drops.
//  FSM:
//   - IDLE -> ALIGN when enable=1. The latch of gen_speed happens on this transition.
//   - ALIGN: discard ALIGN_DELAY sampled bits (delay counter 0..ALIGN_DELAY-1), then go
//     to COLLECT. If ALIGN_DELAY=0, go straight to COLLECT.
//   - COLLECT: bit counter counts 0..N-1.
//     - gen4: bit k lands at word index 7-k.
//     - gen2/gen3: bit k lands at index k.
//   - Both lanes are always shifted in lockstep.
//   - On the edge that samples bit N-1: register both full words to rx_out (including that
//     bit). rx_valid=1 for exactly the following cycle. Bit counter wraps to 0.
//   - Next word's bit 0 is sampled on the very next edge. No gap: back-to-back words every
//     N cycles.
//  descr_rst:
//   - 1 with the first rx_valid after entering COLLECT, 0 on all later words.
//  rx_out:
//   - Holds its value between strobes. Unused upper bits are always 0.
//  enable low (any state, incl. mid-word):
//   - Next edge -> IDLE.
//   - Partial word discarded; no rx_valid.
//   - rx_out cleared to 0; rx_valid and descr_rst forced to 0.
//   - Re-enable restarts at ALIGN with a fresh gen_speed latch.
//  Simultaneous events: enable falling on the bit N-1 edge -> no strobe (enable wins).
//  Latency:
//   - Serial bit N-1 on the wire at edge e -> word visible and rx_valid=1 in cycle e+1.
//   - First strobe after enable rise: ALIGN_DELAY + N cycles (gen3: 134).
//  Counters: 8-bit, never exceed N-1. No overflow or wrap beyond the word boundary.
// TESTING
//  - Reset asserted mid-COLLECT (gen3) -> all outputs 0 immediately; no strobe after
//    release until enable re-handshake.
//  - gen4: enable, 2 idle bits, then bits 1,0,1,0,0,1,0,1 on lane 0 and inverted on
//    lane 1 -> lane_0_rx_out=8'hA5, lane_1_rx_out=8'h5A. rx_valid and descr_rst high
//    together at cycle 10.
//  - gen3: stream 132'h1_2345_6789_ABCD_EF01_2345_6789_ABCD_EF01 LSB first, twice ->
//    two strobes 132 cycles apart. Identical words; descr_rst only on the first.
//  - gen2: back-to-back 66'h2_AAAA_5555_AAAA_5555 then 66'h0 -> strobes at cycles 68 and
//    134. Bits [131:66] stay 0.
//  - enable dropped at bit 40 of a gen3 word -> no rx_valid, rx_out=0. Re-enable with
//    gen_speed=10 -> first 66b word strobed at cycle 68 with descr_rst=1.
//  - gen_speed toggled 01->00 while enabled -> framing stays 132b; words are unaffected.

Source files
------------

// File: rtl/lanes_deserializer.sv
// Two-lane receive deserializer: rebuilds 8b/132b/66b words from lockstep serial lanes
// and strobes them to the descrambler, with a seed-reset pulse on each session's first word.
module lanes_deserializer #(
  parameter int ALIGN_DELAY = 2,
  parameter int MAX_W       = 132
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [1:0]       gen_speed,
  input  logic             lane_0_rx_in,
  input  logic             lane_1_rx_in,
  output logic [MAX_W-1:0] lane_0_rx_out,
  output logic [MAX_W-1:0] lane_1_rx_out,
  output logic             rx_valid,
  output logic             descr_rst
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ALIGN   = 2'd1,
    COLLECT = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [1:0]       gen_lat, gen_nxt;
  logic [7:0]       bit_cnt, bit_cnt_nxt;
  logic [7:0]       dly_cnt, dly_cnt_nxt;
  logic             first_word, first_nxt;
  logic [MAX_W-1:0] sh0, sh0_nxt;
  logic [MAX_W-1:0] sh1, sh1_nxt;
  logic [MAX_W-1:0] out0_nxt, out1_nxt;
  logic             valid_nxt, descr_nxt;

  logic             sample;
  logic [1:0]       cur_gen;
  logic [7:0]       n_cur;
  logic [7:0]       idx;
  logic             lsb_first;
  logic [MAX_W-1:0] word_mask;

  function automatic logic [7:0] word_len(input logic [1:0] g);
    case (g)
      2'b01:   word_len = 8'd132;
      2'b10:   word_len = 8'd66;
      default: word_len = 8'd8;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      gen_lat       <= 2'b00;
      bit_cnt       <= 8'd0;
      dly_cnt       <= 8'd0;
      first_word    <= 1'b0;
      sh0           <= '0;
      sh1           <= '0;
      lane_0_rx_out <= '0;
      lane_1_rx_out <= '0;
      rx_valid      <= 1'b0;
      descr_rst     <= 1'b0;
    end else begin
      state         <= state_nxt;
      gen_lat       <= gen_nxt;
      bit_cnt       <= bit_cnt_nxt;
      dly_cnt       <= dly_cnt_nxt;
      first_word    <= first_nxt;
      sh0           <= sh0_nxt;
      sh1           <= sh1_nxt;
      lane_0_rx_out <= out0_nxt;
      lane_1_rx_out <= out1_nxt;
      rx_valid      <= valid_nxt;
      descr_rst     <= descr_nxt;
    end
  end

  // The enable-rise edge itself counts as the first discarded alignment sample, so the
  // first strobe lands exactly ALIGN_DELAY + N cycles after enable rises.
  always_comb begin
    state_nxt   = state;
    gen_nxt     = gen_lat;
    bit_cnt_nxt = bit_cnt;
    dly_cnt_nxt = dly_cnt;
    first_nxt   = first_word;
    sh0_nxt     = sh0;
    sh1_nxt     = sh1;
    out0_nxt    = lane_0_rx_out;
    out1_nxt    = lane_1_rx_out;
    valid_nxt   = 1'b0;
    descr_nxt   = 1'b0;
    sample      = 1'b0;
    cur_gen     = gen_lat;
    idx         = 8'd0;
    word_mask   = '0;

    if (!enable) begin
      state_nxt   = IDLE;
      bit_cnt_nxt = 8'd0;
      dly_cnt_nxt = 8'd0;
      first_nxt   = 1'b0;
      sh0_nxt     = '0;
      sh1_nxt     = '0;
      out0_nxt    = '0;
      out1_nxt    = '0;
    end else begin
      case (state)
        IDLE: begin
          gen_nxt     = gen_speed;
          cur_gen     = gen_speed;
          first_nxt   = 1'b1;
          bit_cnt_nxt = 8'd0;
          dly_cnt_nxt = 8'd0;
          if (ALIGN_DELAY == 0) begin
            state_nxt = COLLECT;
            sample    = 1'b1;
          end else if (ALIGN_DELAY == 1) begin
            state_nxt = COLLECT;
          end else begin
            state_nxt   = ALIGN;
            dly_cnt_nxt = 8'd1;
          end
        end
        ALIGN: begin
          if (int'(dly_cnt) >= ALIGN_DELAY - 1) begin
            state_nxt   = COLLECT;
            dly_cnt_nxt = 8'd0;
          end else begin
            dly_cnt_nxt = dly_cnt + 8'd1;
          end
        end
        COLLECT: sample = 1'b1;
        default: state_nxt = IDLE;
      endcase
    end

    n_cur     = word_len(cur_gen);
    lsb_first = (cur_gen == 2'b01) || (cur_gen == 2'b10);
    for (int i = 0; i < MAX_W; i++) word_mask[i] = (i < int'(n_cur));

    // gen4 bytes arrive MSB first; the wide gen2/gen3 blocks arrive LSB first.
    if (sample) begin
      idx          = lsb_first ? bit_cnt : (8'd7 - bit_cnt);
      sh0_nxt[idx] = lane_0_rx_in;
      sh1_nxt[idx] = lane_1_rx_in;
      if (bit_cnt == n_cur - 8'd1) begin
        out0_nxt    = sh0_nxt & word_mask;
        out1_nxt    = sh1_nxt & word_mask;
        valid_nxt   = 1'b1;
        descr_nxt   = first_nxt;
        first_nxt   = 1'b0;
        bit_cnt_nxt = 8'd0;
        sh0_nxt     = '0;
        sh1_nxt     = '0;
      end else begin
        bit_cnt_nxt = bit_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_lanes_deserializer.sv
// Directed self-checking bench for lanes_deserializer: gen4/gen3/gen2 framing,
// back-to-back words, enable drop, gen_speed lock and asynchronous reset.
module tb_lanes_deserializer;

  localparam logic [131:0] W4_0    = 132'hA5;
  localparam logic [131:0] W4_1    = 132'h5A;
  localparam logic [131:0] W3A     = 132'h1_2345_6789_ABCD_EF01_2345_6789_ABCD_EF01;
  localparam logic [131:0] W3B     = 132'h0_FEDC_BA98_7654_3210_0F0F_F0F0_1234_5678;
  localparam logic [131:0] W2A     = {66'h0, 66'h2_AAAA_5555_AAAA_5555};
  localparam logic [131:0] W2A_INV = {66'h0, 66'h1_5555_AAAA_5555_AAAA};
  localparam logic [131:0] W2_ONES = {66'h0, {66{1'b1}}};
  localparam logic [131:0] ZERO    = '0;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic [1:0]   gen_speed;
  logic         lane_0_rx_in;
  logic         lane_1_rx_in;
  logic [131:0] lane_0_rx_out;
  logic [131:0] lane_1_rx_out;
  logic         rx_valid;
  logic         descr_rst;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  lanes_deserializer #(.ALIGN_DELAY(2), .MAX_W(132)) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .gen_speed     (gen_speed),
    .lane_0_rx_in  (lane_0_rx_in),
    .lane_1_rx_in  (lane_1_rx_in),
    .lane_0_rx_out (lane_0_rx_out),
    .lane_1_rx_out (lane_1_rx_out),
    .rx_valid      (rx_valid),
    .descr_rst     (descr_rst)
  );

  task automatic step(input logic b0, input logic b1);
    lane_0_rx_in = b0;
    lane_1_rx_in = b1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Enable rises here; the two steps are the discarded alignment samples (driven as 1s).
  task automatic start_session(input logic [1:0] g);
    gen_speed = g;
    enable    = 1'b1;
    cyc       = 0;
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
  endtask

  task automatic send_word(input logic [131:0] w0, input logic [131:0] w1,
                           input int n, input bit msb_first, output int early);
    early = 0;
    for (int i = 0; i < n; i++) begin
      int k;
      k = msb_first ? (n - 1 - i) : i;
      step(w0[k], w1[k]);
      if (i < n - 1 && rx_valid !== 1'b0) early++;
    end
  endtask

  task automatic stop_session();
    enable = 1'b0;
    step(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    n_checks++;
    if (rx_valid !== 1'b0 || descr_rst !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_strobes: got valid=%b descr=%b expected 0 0", rx_valid, descr_rst);
    end
    n_checks++;
    if (lane_0_rx_out !== ZERO || lane_1_rx_out !== ZERO) begin
      n_fail++;
      $display("[TB] FAIL reset_words: got %h / %h expected 0", lane_0_rx_out, lane_1_rx_out);
    end
  endtask

  task automatic test_gen4();
    int early;
    start_session(2'b00);
    send_word(W4_0, W4_1, 8, 1'b1, early);
    n_checks++;
    if (early !== 0) begin
      n_fail++;
      $display("[TB] FAIL gen4_early_strobe: got %0d early strobes expected 0", early);
    end
    n_checks++;
    if (rx_valid !== 1'b1 || descr_rst !== 1'b1 || cyc !== 10) begin
      n_fail++;
      $display("[TB] FAIL gen4_strobe: got valid=%b descr=%b at cycle %0d expected 1 1 at 10",
               rx_valid, descr_rst, cyc);
    end
    n_checks++;
    if (lane_0_rx_out !== W4_0 || lane_1_rx_out !== W4_1) begin
      n_fail++;
      $display("[TB] FAIL gen4_words: got %h / %h expected %h / %h",
               lane_0_rx_out, lane_1_rx_out, W4_0, W4_1);
    end
    step(1'b0, 1'b0);
    n_checks++;
    if (rx_valid !== 1'b0 || descr_rst !== 1'b0 || lane_0_rx_out !== W4_0) begin
      n_fail++;
      $display("[TB] FAIL gen4_hold: got valid=%b descr=%b out0=%h expected 0 0 %h",
               rx_valid, descr_rst, lane_0_rx_out, W4_0);
    end
    stop_session();
    n_checks++;
    if (lane_0_rx_out !== ZERO || lane_1_rx_out !== ZERO) begin
      n_fail++;
      $display("[TB] FAIL gen4_disable_clear: got %h / %h expected 0", lane_0_rx_out, lane_1_rx_out);
    end
  endtask

  task automatic test_gen3();
    int early;
    start_session(2'b01);
    send_word(W3A, W3B, 132, 1'b0, early);
    n_checks++;
    if (early !== 0 || rx_valid !== 1'b1 || descr_rst !== 1'b1 || cyc !== 134) begin
      n_fail++;
      $display("[TB] FAIL gen3_first_strobe: got early=%0d valid=%b descr=%b cycle %0d expected 0 1 1 134",
               early, rx_valid, descr_rst, cyc);
    end
    n_checks++;
    if (lane_0_rx_out !== W3A || lane_1_rx_out !== W3B) begin
      n_fail++;
      $display("[TB] FAIL gen3_first_words: got %h / %h expected %h / %h",
               lane_0_rx_out, lane_1_rx_out, W3A, W3B);
    end
    send_word(W3A, W3B, 132, 1'b0, early);
    n_checks++;
    if (early !== 0 || rx_valid !== 1'b1 || descr_rst !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL gen3_second_strobe: got early=%0d valid=%b descr=%b expected 0 1 0",
               early, rx_valid, descr_rst);
    end
    n_checks++;
    if (lane_0_rx_out !== W3A || lane_1_rx_out !== W3B) begin
      n_fail++;
      $display("[TB] FAIL gen3_second_words: got %h / %h expected %h / %h",
               lane_0_rx_out, lane_1_rx_out, W3A, W3B);
    end
    stop_session();
  endtask

  task automatic test_gen2_back_to_back();
    int early;
    start_session(2'b10);
    send_word(W2A, W2A_INV, 66, 1'b0, early);
    n_checks++;
    if (early !== 0 || rx_valid !== 1'b1 || descr_rst !== 1'b1 || cyc !== 68) begin
      n_fail++;
      $display("[TB] FAIL gen2_first_strobe: got early=%0d valid=%b descr=%b cycle %0d expected 0 1 1 68",
               early, rx_valid, descr_rst, cyc);
    end
    n_checks++;
    if (lane_0_rx_out !== W2A || lane_1_rx_out !== W2A_INV) begin
      n_fail++;
      $display("[TB] FAIL gen2_first_words: got %h / %h expected %h / %h",
               lane_0_rx_out, lane_1_rx_out, W2A, W2A_INV);
    end
    send_word(ZERO, W2_ONES, 66, 1'b0, early);
    n_checks++;
    if (early !== 0 || rx_valid !== 1'b1 || descr_rst !== 1'b0 || cyc !== 134) begin
      n_fail++;
      $display("[TB] FAIL gen2_second_strobe: got early=%0d valid=%b descr=%b cycle %0d expected 0 1 0 134",
               early, rx_valid, descr_rst, cyc);
    end
    n_checks++;
    if (lane_0_rx_out !== ZERO || lane_1_rx_out !== W2_ONES) begin
      n_fail++;
      $display("[TB] FAIL gen2_second_words: got %h / %h expected %h / %h",
               lane_0_rx_out, lane_1_rx_out, ZERO, W2_ONES);
    end
    stop_session();
  endtask

  task automatic test_enable_drop();
    int early;
    int stray;
    start_session(2'b01);
    send_word(W3A, W3B, 132, 1'b0, early);
    for (int i = 0; i < 40; i++) step(W3B[i], W3A[i]);
    enable = 1'b0;
    step(W3B[40], W3A[40]);
    n_checks++;
    if (rx_valid !== 1'b0 || lane_0_rx_out !== ZERO || lane_1_rx_out !== ZERO) begin
      n_fail++;
      $display("[TB] FAIL drop_mid_word: got valid=%b out=%h / %h expected 0 0 0",
               rx_valid, lane_0_rx_out, lane_1_rx_out);
    end
    stray = 0;
    for (int i = 0; i < 150; i++) begin
      step(1'b1, 1'b0);
      if (rx_valid !== 1'b0) stray++;
    end
    n_checks++;
    if (stray !== 0) begin
      n_fail++;
      $display("[TB] FAIL drop_idle_strobes: got %0d strobes expected 0", stray);
    end
    start_session(2'b10);
    send_word(W2A, W2A_INV, 66, 1'b0, early);
    n_checks++;
    if (early !== 0 || rx_valid !== 1'b1 || descr_rst !== 1'b1 || cyc !== 68 ||
        lane_0_rx_out !== W2A) begin
      n_fail++;
      $display("[TB] FAIL drop_reenable_gen2: got early=%0d valid=%b descr=%b cycle %0d out0=%h expected 0 1 1 68 %h",
               early, rx_valid, descr_rst, cyc, lane_0_rx_out, W2A);
    end
    stop_session();
    // enable falls on the same edge that samples the last gen4 bit
    start_session(2'b00);
    for (int i = 0; i < 7; i++) step(W4_0[7-i], W4_1[7-i]);
    enable = 1'b0;
    step(W4_0[0], W4_1[0]);
    n_checks++;
    if (rx_valid !== 1'b0 || descr_rst !== 1'b0 || lane_0_rx_out !== ZERO) begin
      n_fail++;
      $display("[TB] FAIL drop_on_last_bit: got valid=%b descr=%b out0=%h expected 0 0 0",
               rx_valid, descr_rst, lane_0_rx_out);
    end
  endtask

  task automatic test_gen_speed_lock();
    int early;
    start_session(2'b01);
    gen_speed = 2'b00;
    send_word(W3B, W3A, 132, 1'b0, early);
    n_checks++;
    if (early !== 0 || rx_valid !== 1'b1 || descr_rst !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL lock_strobe: got early=%0d valid=%b descr=%b expected 0 1 1",
               early, rx_valid, descr_rst);
    end
    n_checks++;
    if (lane_0_rx_out !== W3B || lane_1_rx_out !== W3A) begin
      n_fail++;
      $display("[TB] FAIL lock_words: got %h / %h expected %h / %h",
               lane_0_rx_out, lane_1_rx_out, W3B, W3A);
    end
    stop_session();
  endtask

  task automatic test_reset_mid_collect();
    int early;
    int stray;
    start_session(2'b01);
    send_word(W3A, W3B, 132, 1'b0, early);
    for (int i = 0; i < 20; i++) step(W3A[i], W3B[i]);
    rst = 1'b0;
    #1;
    n_checks++;
    if (rx_valid !== 1'b0 || descr_rst !== 1'b0 || lane_0_rx_out !== ZERO || lane_1_rx_out !== ZERO) begin
      n_fail++;
      $display("[TB] FAIL async_reset: got valid=%b descr=%b out=%h / %h expected all 0",
               rx_valid, descr_rst, lane_0_rx_out, lane_1_rx_out);
    end
    enable = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    stray = 0;
    for (int i = 0; i < 140; i++) begin
      step(W3A[i], W3B[i]);
      if (rx_valid !== 1'b0) stray++;
    end
    n_checks++;
    if (stray !== 0) begin
      n_fail++;
      $display("[TB] FAIL reset_no_strobe: got %0d strobes expected 0", stray);
    end
    start_session(2'b00);
    send_word(W4_1, W4_0, 8, 1'b1, early);
    n_checks++;
    if (rx_valid !== 1'b1 || descr_rst !== 1'b1 || lane_0_rx_out !== W4_1 || lane_1_rx_out !== W4_0) begin
      n_fail++;
      $display("[TB] FAIL reset_rehandshake: got valid=%b descr=%b out=%h / %h expected 1 1 %h / %h",
               rx_valid, descr_rst, lane_0_rx_out, lane_1_rx_out, W4_1, W4_0);
    end
    stop_session();
  endtask

  initial begin
    rst          = 1'b0;
    enable       = 1'b0;
    gen_speed    = 2'b00;
    lane_0_rx_in = 1'b0;
    lane_1_rx_in = 1'b0;
    #12;
    test_reset();
    rst = 1'b1;
    step(1'b0, 1'b0);
    $display("[TB] gen4 byte");
    test_gen4();
    $display("[TB] gen3 repeated block");
    test_gen3();
    $display("[TB] gen2 back-to-back");
    test_gen2_back_to_back();
    $display("[TB] enable drop");
    test_enable_drop();
    $display("[TB] gen_speed lock");
    test_gen_speed_lock();
    $display("[TB] reset mid-collect");
    test_reset_mid_collect();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
